// File: rtl/fifo_rd_burst_ctrl.sv
// Read-side burst drainer for the async FIFO: pulls fixed-length bursts under
// output-buffer credit and presents them as a valid/ready stream with m_last.
module fifo_rd_burst_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEVEL_WIDTH = 13,
    parameter int BURST_LEN   = 16,
    parameter int OBUF_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    input  logic                   flush,
    output logic                   m_valid,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic                   busy,
    output logic                   burst_done
);
    localparam int PTR_W = $clog2(OBUF_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [LEVEL_WIDTH-1:0] BURST_LEN_L = LEVEL_WIDTH'(BURST_LEN);
    localparam logic [OCC_W-1:0]       DEPTH_L     = OCC_W'(OBUF_DEPTH);

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    state_t                 state_q, state_d;
    logic [LEVEL_WIDTH-1:0] len_q, len_d;
    logic [LEVEL_WIDTH-1:0] issued_q, issued_d;
    logic                   inflight_q, inflight_d;
    logic                   cap_last_q, cap_last_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic                   burst_done_q, burst_done_d;
    logic [DATA_WIDTH:0]    obuf_q [OBUF_DEPTH];

    logic                   start_normal;
    logic                   start_flush;
    logic                   last_rd;
    logic                   has_credit;
    logic [OCC_W-1:0]       used;
    logic                   pop;
    logic [DATA_WIDTH:0]    head;

    // Credit counts both buffered words and the read whose data lands next cycle.
    always_comb begin
        start_normal = (fifo_rd_water_level >= BURST_LEN_L);
        start_flush  = flush && !fifo_rd_empty && (fifo_rd_water_level != '0);
        last_rd      = (issued_q == (len_q - LEVEL_WIDTH'(1)));
        used         = occ_q + OCC_W'(inflight_q);
        has_credit   = (used < DEPTH_L);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_normal || start_flush) state_d = BURST;
            BURST:   if (fifo_rd_en && last_rd) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read strobe is also gated by rst_n so nothing is pulled during the reset cycle.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (rst_n && (state_q == BURST)) begin
            fifo_rd_en = (issued_q < len_q) && has_credit && !fifo_rd_empty;
        end
        head       = obuf_q[rd_ptr_q];
        m_valid    = (occ_q != '0);
        m_data     = head[DATA_WIDTH-1:0];
        m_last     = m_valid && head[DATA_WIDTH];
        pop        = m_valid && m_ready;
        busy       = (state_q != IDLE) || m_valid;
        burst_done = burst_done_q;
    end

    always_comb begin
        len_d    = len_q;
        issued_d = issued_q;
        if (state_q == IDLE) begin
            issued_d = '0;
            if (start_normal) begin
                len_d = BURST_LEN_L;
            end else if (start_flush) begin
                len_d = fifo_rd_water_level;
            end
        end else if (fifo_rd_en) begin
            issued_d = issued_q + LEVEL_WIDTH'(1);
        end
        inflight_d   = fifo_rd_en;
        cap_last_d   = fifo_rd_en && last_rd;
        wr_ptr_d     = wr_ptr_q + PTR_W'(inflight_q);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        occ_d        = occ_q + OCC_W'(inflight_q) - OCC_W'(pop);
        burst_done_d = pop && m_last;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q        <= '0;
            issued_q     <= '0;
            inflight_q   <= 1'b0;
            cap_last_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            burst_done_q <= 1'b0;
        end else begin
            len_q        <= len_d;
            issued_q     <= issued_d;
            inflight_q   <= inflight_d;
            cap_last_q   <= cap_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            burst_done_q <= burst_done_d;
        end
    end

    // Buffer contents need no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (inflight_q) begin
            obuf_q[wr_ptr_q] <= {cap_last_q, fifo_rd_data};
        end
    end

endmodule

// File: tb/tb_fifo_rd_burst_ctrl.sv
// Scoreboard bench for fifo_rd_burst_ctrl with a behavioural FIFO (no output register).
module tb_fifo_rd_burst_ctrl;
    localparam int BL = 16;
    localparam int OD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = '0;
    logic        fifo_empty = 1'b1;
    logic [12:0] fifo_level = '0;
    logic        flush = 1'b0;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;
    logic        busy;
    logic        burst_done;

    logic        rdy_rand = 1'b0;
    logic        rdy_man = 1'b1;
    logic        rnd_rdy = 1'b0;

    int total = 0;
    int bad = 0;

    logic [31:0] fq[$];
    logic [31:0] pend[$];
    logic [32:0] exp_q[$];
    logic [32:0] e_ent;

    int pops = 0;
    int rd_cnt = 0;
    int bd_cnt = 0;
    int busy_cnt = 0;
    int cyc = 0;
    int outstanding = 0;
    int low_run = 0;
    int last_gap = 0;
    int rd_rise_cyc = 0;
    int vld_rise_cyc = 0;
    bit seen_rd = 0;
    bit prev_rd = 0;
    bit prev_vld = 0;
    bit prev_hs_last = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last_v = 1'b0;

    always #5 clk = ~clk;

    assign m_ready = rdy_rand ? rnd_rdy : rdy_man;

    fifo_rd_burst_ctrl #(
        .DATA_WIDTH (32),
        .LEVEL_WIDTH(13),
        .BURST_LEN  (BL),
        .OBUF_DEPTH (OD)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fifo_rd_en         (fifo_rd_en),
        .fifo_rd_data       (fifo_rd_data),
        .fifo_rd_empty      (fifo_empty),
        .fifo_rd_water_level(fifo_level),
        .flush              (flush),
        .m_valid            (m_valid),
        .m_data             (m_data),
        .m_last             (m_last),
        .m_ready            (m_ready),
        .busy               (busy),
        .burst_done         (burst_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // FIFO model: data registered on the edge that sees rd_en, level follows immediately.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            pops = pops + 1;
            if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
            else fifo_rd_data <= 32'hDEAD_BEEF;
        end
        while (pend.size() > 0) fq.push_back(pend.pop_front());
        fifo_level <= 13'(fq.size());
        fifo_empty <= (fq.size() == 0);
    end

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(99) < 30);
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            outstanding  = 0;
            prev_hs_last = 0;
            prev_stall   = 0;
            prev_rd      = 0;
            prev_vld     = 0;
        end else begin
            chk("burst_done", burst_done, prev_hs_last);
            if (burst_done) bd_cnt = bd_cnt + 1;
            if (busy) busy_cnt = busy_cnt + 1;
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last_v);
            end
            if (fifo_rd_en) begin
                chk("credit", outstanding < OD, 1);
                outstanding = outstanding + 1;
                rd_cnt = rd_cnt + 1;
                if (!prev_rd) begin
                    rd_rise_cyc = cyc;
                    if (seen_rd) last_gap = low_run;
                end
                low_run = 0;
                seen_rd = 1;
            end else begin
                low_run = low_run + 1;
            end
            if (m_valid && !prev_vld) vld_rise_cyc = cyc;
            if (m_valid && m_ready) begin
                outstanding = outstanding - 1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: actual=%0h required=none", m_data);
                end else begin
                    e_ent = exp_q.pop_front();
                    chk("data", m_data, e_ent[31:0]);
                    chk("last", m_last, e_ent[32]);
                end
            end
            prev_hs_last = m_valid && m_ready && m_last;
            prev_stall   = m_valid && !m_ready;
            prev_data    = m_data;
            prev_last_v  = m_last;
            prev_rd      = fifo_rd_en;
            prev_vld     = m_valid;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] first, input int n, input int step);
        for (int i = 0; i < n; i++) pend.push_back(first + 32'(i * step));
    endtask

    task automatic expect_seq(input logic [31:0] first, input int n, input int step);
        logic lst;
        for (int i = 0; i < n; i++) begin
            lst = (((i + 1) % BL) == 0) || (i == n - 1);
            exp_q.push_back({lst, first + 32'(i * step)});
        end
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        tick;
        while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
            tick;
            n++;
        end
        chk(name, n < max_cyc, 1);
        repeat (2) tick;
    endtask

    initial begin
        int bd0;
        int rd0;
        int bz0;
        int p0;

        repeat (3) tick;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_burst_done", burst_done, 0);
        rst_n = 1'b1;
        tick;

        // Single full burst, descending data
        bd0 = bd_cnt;
        push_seq(32'hFFFF_FFFF, 16, -1);
        expect_seq(32'hFFFF_FFFF, 16, -1);
        wait_idle("t1_idle", 300);
        chk("t1_bursts", bd_cnt - bd0, 1);
        chk("t1_latency", vld_rise_cyc - rd_rise_cyc, 2);

        // Two bursts back to back, then flush the 8-word remainder
        bd0 = bd_cnt;
        push_seq(32'h1000_0000, 40, 1);
        expect_seq(32'h1000_0000, 32, 1);
        wait_idle("t2_idle", 300);
        chk("t2_bursts", bd_cnt - bd0, 2);
        chk("t2_gap", last_gap, 2);
        chk("t2_level", fifo_level, 8);
        chk("t2_busy", busy, 0);
        bd0 = bd_cnt;
        expect_seq(32'h1000_0020, 8, 1);
        flush = 1'b1;
        wait_idle("t2_flush_idle", 200);
        flush = 1'b0;
        chk("t2_flush_bursts", bd_cnt - bd0, 1);
        chk("t2_flush_level", fifo_level, 0);

        // Random 30% ready
        bd0 = bd_cnt;
        rdy_rand = 1'b1;
        push_seq(32'h2000_0000, 32, 3);
        expect_seq(32'h2000_0000, 32, 3);
        wait_idle("t3_idle", 3000);
        rdy_rand = 1'b0;
        tick;
        chk("t3_bursts", bd_cnt - bd0, 2);

        // Consumer stalled: reads stop at buffer depth
        bd0 = bd_cnt;
        rd0 = rd_cnt;
        rdy_man = 1'b0;
        push_seq(32'h4000_0000, 16, 1);
        expect_seq(32'h4000_0000, 16, 1);
        repeat (20) tick;
        chk("t4_stall_reads", rd_cnt - rd0, OD);
        chk("t4_stall_rd_en", fifo_rd_en, 0);
        chk("t4_stall_valid", m_valid, 1);
        rdy_man = 1'b1;
        wait_idle("t4_idle", 300);
        chk("t4_total_reads", rd_cnt - rd0, 16);
        chk("t4_bursts", bd_cnt - bd0, 1);

        // Reset after five reads
        p0 = pops;
        push_seq(32'h5000_0000, 16, 1);
        expect_seq(32'h5000_0000, 16, 1);
        for (int i = 0; i < 200 && pops < p0 + 5; i++) tick;
        chk("t5_reads_before_rst", pops - p0, 5);
        rst_n = 1'b0;
        tick;
        chk("t5_rd_en", fifo_rd_en, 0);
        chk("t5_m_valid", m_valid, 0);
        chk("t5_m_last", m_last, 0);
        chk("t5_busy", busy, 0);
        chk("t5_burst_done", burst_done, 0);
        chk("t5_level", fifo_level, 11);
        exp_q.delete();
        rst_n = 1'b1;
        rd0 = rd_cnt;
        bz0 = busy_cnt;
        repeat (12) tick;
        chk("t5_no_start_reads", rd_cnt - rd0, 0);
        chk("t5_no_start_busy", busy_cnt - bz0, 0);
        bd0 = bd_cnt;
        expect_seq(32'h5000_0005, 11, 1);
        flush = 1'b1;
        wait_idle("t5_flush_idle", 200);
        flush = 1'b0;
        chk("t5_flush_bursts", bd_cnt - bd0, 1);

        // Flush with an empty FIFO
        rd0 = rd_cnt;
        bz0 = busy_cnt;
        flush = 1'b1;
        repeat (10) tick;
        flush = 1'b0;
        chk("t6_reads", rd_cnt - rd0, 0);
        chk("t6_busy", busy_cnt - bz0, 0);

        chk("exp_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
